// File: rtl/nandn_pkg.sv
// nandn_pkg: shared limits, defaults and filter-state encoding for nandn_deglitch
package nandn_pkg;
  localparam int N_IN_MAX   = 8;
  localparam int FILT_W_DEF = 4;
  localparam int GLITCH_W   = 8;
  typedef enum logic [1:0] {FS_OFF, FS_STABLE, FS_QUAL, FS_COMMIT} filt_state_e;
endpackage

// File: rtl/nandn_sync2.sv
// nandn_sync2: two-flop synchronizer with a configurable reset value
module nandn_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;
  assign o_q = r_s2;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {r_s2, r_s1} <= {2{RST_VAL}};
    else {r_s2, r_s1} <= {r_s1, i_d};
endmodule

// File: rtl/nandn_deglitch.sv
// nandn_deglitch: N-input NAND/AND gate followed by a synchronizer and a length-qualified glitch filter.
// Define NANDN_DEGLITCH_GLITCH_CNT_EN to add the rejected-glitch counter (clr_glitch / glitch_cnt).
module nandn_deglitch
  import nandn_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int FILT_W  = FILT_W_DEF,
  parameter int INV_OUT = 1
) (
  input  logic              CELCLK,
  input  logic              CELRST,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic [N_IN-1:0]   i,
  input  logic              en,
  input  logic [FILT_W-1:0] filt_len,
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
  input  logic                clr_glitch,
  output logic [GLITCH_W-1:0] glitch_cnt,
`endif
  output logic              o,
  output logic              o_raw,
  output logic              chg
);
  localparam logic RST_O = INV_OUT != 0;
  localparam logic [FILT_W-1:0] CNT_MAX = '1;
  if (N_IN < 2 || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("nandn_deglitch: N_IN=%0d outside 2..%0d", N_IN, N_IN_MAX);
  end
  logic w_s2, w_unused;
  logic r_o, r_chg;
  logic [FILT_W-1:0] r_cnt;
  filt_state_e w_state;
  assign o_raw = RST_O ? ~&i : &i;
  assign w_unused = ^{CELV, CELG, SUB};
  assign o = r_o;
  assign chg = r_chg;
  nandn_sync2 #(.RST_VAL(RST_O)) u_sync (
    .i_clk(CELCLK),
    .i_rst(CELRST),
    .i_d  (o_raw),
    .o_q  (w_s2)
  );
  // >= lets a lowered filt_len take effect on the very next edge
  assign w_state = !en ? FS_OFF : w_s2 == r_o ? FS_STABLE : r_cnt >= filt_len ? FS_COMMIT : FS_QUAL;
  always_ff @(posedge CELCLK or posedge CELRST)
    if (CELRST) begin
      r_o   <= RST_O;
      r_cnt <= '0;
      r_chg <= 1'b0;
    end else begin
      r_o   <= w_state == FS_COMMIT ? w_s2 : r_o;
      r_chg <= w_state == FS_COMMIT;
      r_cnt <= w_state != FS_QUAL ? '0 : r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1;
    end
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch;
  assign glitch_cnt = r_glitch;
  // a qualification that collapses back to the held value is a rejected glitch
  always_ff @(posedge CELCLK or posedge CELRST)
    if (CELRST) r_glitch <= '0;
    else if (clr_glitch) r_glitch <= '0;
    else if (w_state == FS_STABLE && r_cnt != '0 && r_glitch != '1) r_glitch <= r_glitch + 1'b1;
`endif
endmodule

// File: tb/tb_nandn_deglitch.sv
// tb_nandn_deglitch: directed scenarios plus random stimulus against a history-based reference model
module tb_nandn_deglitch;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [3:0] filt_len = 4'd0;
  logic [1:0] i2 = 2'b00;
  logic [7:0] i8 = 8'h00;
  logic o2, raw2, chg2, o8, raw8, chg8;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic m_o [2];
  logic m_chg [2];
  int m_run [2];
  logic [1:0] hist [$];
  int q0 [$];
  int q1 [$];
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
  logic clr = 1'b0;
  logic [7:0] g2, g8;
  int m_g [2];
`endif

  always #5 clk = ~clk;

  nandn_deglitch #(.N_IN(2), .FILT_W(4), .INV_OUT(1)) u2 (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i2), .en(en), .filt_len(filt_len),
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
    .clr_glitch(clr), .glitch_cnt(g2),
`endif
    .o(o2), .o_raw(raw2), .chg(chg2)
  );

  nandn_deglitch #(.N_IN(8), .FILT_W(4), .INV_OUT(0)) u8 (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i8), .en(en), .filt_len(filt_len),
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
    .clr_glitch(clr), .glitch_cnt(g8),
`endif
    .o(o8), .o_raw(raw8), .chg(chg8)
  );

  // Reference: o follows the gate value seen two edges earlier once it has
  // disagreed with o on more than filt_len consecutive enabled edges.
  always @(posedge clk or posedge rst) begin
    logic sv;
    if (rst) begin
      m_o = '{1'b1, 1'b0};
      m_chg = '{1'b0, 1'b0};
      m_run = '{0, 0};
      hist = '{2'b01, 2'b01};
      q0.delete();
      q1.delete();
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
      m_g = '{0, 0};
`endif
    end else begin
      cyc++;
      hist.push_back({&i8, ~&i2});
      while (hist.size() > 3) void'(hist.pop_front());
      for (int d = 0; d < 2; d++) begin
        sv = hist[0][d];
        m_chg[d] = 1'b0;
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
        if (clr) m_g[d] = 0;
        else if (en && sv == m_o[d] && m_run[d] > 0 && m_g[d] < 255) m_g[d]++;
`endif
        if (!en || sv == m_o[d]) m_run[d] = 0;
        else if (m_run[d] >= int'(filt_len)) begin
          m_o[d] = sv;
          m_run[d] = 0;
          m_chg[d] = 1'b1;
          if (d == 0) q0.push_back(cyc * 2 + int'(sv));
          else q1.push_back(cyc * 2 + int'(sv));
        end else m_run[d]++;
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic sb(int d, logic v);
    int e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb%0d_unexpected: got chg with o=%0d expected no chg at t=%0t", d, v, $time);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("sb%0d_val", d), int'(v), e % 2);
    chk($sformatf("sb%0d_cyc", d), cyc, e / 2);
  endtask

  always @(negedge clk) begin
    chk("o2", int'(o2), int'(m_o[0]));
    chk("o8", int'(o8), int'(m_o[1]));
    chk("chg2", int'(chg2), int'(m_chg[0]));
    chk("chg8", int'(chg8), int'(m_chg[1]));
    chk("raw2", int'(raw2), int'(~&i2));
    chk("raw8", int'(raw8), int'(&i8));
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
    chk("glitch2", int'(g2), m_g[0]);
    chk("glitch8", int'(g8), m_g[1]);
`endif
    if (chg2) sb(0, o2);
    if (chg8) sb(1, o8);
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    step(2);
    chk("rst_o2", int'(o2), 1);
    chk("rst_o8", int'(o8), 0);
    chk("rst_chg2", int'(chg2), 0);
    rst = 1'b0;
    step(3);
    i2 = 2'b11;
    step(2);
    chk("fl0_hold", int'(o2), 1);
    step(1);
    chk("fl0_fall", int'(o2), 0);
    chk("fl0_chg", int'(chg2), 1);
    step(1);
    chk("fl0_chg_once", int'(chg2), 0);
    i2 = 2'b00;
    step(4);
    chk("fl0_rise", int'(o2), 1);
    filt_len = 4'd3;
    i2 = 2'b11;
    step(5);
    chk("fl3_hold", int'(o2), 1);
    step(1);
    chk("fl3_fall", int'(o2), 0);
    i2 = 2'b00;
    step(2);
    i2 = 2'b11;
    step(8);
    chk("pulse_reject", int'(o2), 0);
    filt_len = 4'd10;
    i2 = 2'b00;
    step(8);
    chk("fl10_hold", int'(o2), 0);
    filt_len = 4'd4;
    step(1);
    chk("shrink_update", int'(o2), 1);
    filt_len = 4'd10;
    i2 = 2'b11;
    step(9);
    chk("pre_rst_hold", int'(o2), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_o", int'(o2), 1);
    chk("rst_mid_chg", int'(chg2), 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("rel_nochg", int'(chg2), 0);
    step(11);
    chk("rel_restart_hold", int'(o2), 1);
    step(1);
    chk("rel_restart_fall", int'(o2), 0);
    filt_len = 4'd3;
    en = 1'b0;
    i8 = 8'hFF;
    step(20);
    chk("en0_hold", int'(o8), 0);
    en = 1'b1;
    step(3);
    chk("en1_hold", int'(o8), 0);
    step(1);
    chk("en1_rise", int'(o8), 1);
    chk("en1_chg", int'(chg8), 1);
    filt_len = 4'd15;
    i2 = 2'b00;
    step(17);
    chk("max_hold", int'(o2), 0);
    step(1);
    chk("max_rise", int'(o2), 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) i2 = 2'($urandom);
      if ($urandom_range(3) == 0) i8 = 8'hFF ^ 8'($urandom_range(1));
      en = $urandom_range(15) != 0;
      if ($urandom_range(31) == 0) filt_len = 4'($urandom_range(5));
      rst = $urandom_range(199) == 0;
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
      clr = $urandom_range(63) == 0;
`endif
      step(1);
    end
    rst = 1'b0;
    en = 1'b1;
`ifdef NANDN_DEGLITCH_GLITCH_CNT_EN
    clr = 1'b0;
`endif
    step(25);
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nandn_deglitch.md
NANDN_DEGLITCH -- requirements
Module: nandn_deglitch

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, giving the NAND input count; legal range is 2..8.
REQ-002 The block SHALL have parameter FILT_W, default 4, giving the filter-length and counter width.
REQ-003 The block SHALL have parameter INV_OUT, default 1; 1 selects the NAND function and 0 selects AND.
REQ-004 The block SHALL have port CELCLK, input, 1 bit: the single clock, with all flops on its rising edge.
REQ-005 The block SHALL have port CELRST, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have ports CELV, CELG and SUB, each input, 1 bit: supply, ground and substrate pass-through pins with no logic function.
REQ-007 The block SHALL have port i, input, N_IN bits: the logic inputs, asynchronous to CELCLK.
REQ-008 The block SHALL have port en, input, 1 bit: the filter enable.
REQ-009 The block SHALL have port filt_len, input, FILT_W bits: the required stable cycles before o changes.
REQ-010 The block SHALL have port o, output, 1 bit: the filtered, registered gate output.
REQ-011 The block SHALL have port o_raw, output, 1 bit: the combinational, unfiltered gate result, for debug.
REQ-012 The block SHALL have port chg, output, 1 bit: a one-cycle pulse in the first cycle o holds a new value.

Function
REQ-013 o_raw SHALL be ~&i when INV_OUT=1 and &i when INV_OUT=0.
REQ-014 o_raw SHALL pass through a two-flop synchronizer (s1, s2) before filtering.
REQ-015 On each edge with en=1 and s2!=o: if cnt>=filt_len then o<=s2 and cnt<=0, else cnt<=cnt+1.
REQ-016 On each edge with en=1 and s2==o, cnt SHALL clear to 0.
REQ-017 The comparison SHALL be >= (not ==), so lowering filt_len mid-count with cnt above the new value updates o on the next edge.
REQ-018 Latency: with i settled before edge 0, o SHALL take the new value after edge filt_len+2; filt_len=0 gives 3 edges.
REQ-019 With en=0, o SHALL hold, cnt SHALL clear, and the synchronizer SHALL keep running; re-enabling restarts qualification from cnt=0.
REQ-020 chg SHALL be registered, high for exactly one cycle coinciding with the first cycle of a new o value, and low otherwise.
REQ-021 cnt SHALL never wrap; it saturates at 2^FILT_W-1, and filt_len=2^FILT_W-1 remains reachable.

Reset
REQ-022 While CELRST=1, s1, s2 and o SHALL equal INV_OUT (the gate result for all-zero inputs), with cnt=0 and chg=0.
REQ-023 Reset assertion mid-qualification SHALL abort it immediately; deassertion SHALL produce no chg pulse.

Configuration
REQ-024 With macro NANDN_DEGLITCH_GLITCH_CNT_EN defined, the block SHALL add input clr_glitch (1 bit) and output glitch_cnt (8 bits).
REQ-025 Under that macro, glitch_cnt SHALL increment on each edge where en=1, s2==o and cnt>0, saturating at 255.
REQ-026 clr_glitch=1 SHALL zero glitch_cnt and take priority over a simultaneous increment; reset SHALL zero glitch_cnt.
REQ-027 Without the macro, clr_glitch, glitch_cnt and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Package nandn_pkg SHALL hold N_IN_MAX=8, FILT_W_DEF=4, GLITCH_W=8 and the filter-state typedef.
REQ-029 Sub-module nandn_sync2 SHALL implement the two-flop synchronizer with a reset-value parameter.
REQ-030 Elaboration SHALL fail when N_IN is outside 2..8.

Verification
REQ-031 Scenario: N_IN=2, INV_OUT=1, filt_len=0; i 00->11 settled before edge 0 -> o 1->0 after edge 2, chg high one cycle.
REQ-032 Scenario: filt_len=3; i=11 held 5 cycles -> o falls after edge 5; a 2-cycle pulse -> o never changes.
REQ-033 Scenario (with macro): three 2-cycle glitches at filt_len=5 -> glitch_cnt=3; clr_glitch concurrent with a fourth glitch end -> 0.
REQ-034 Scenario: filt_len=10 and cnt=6, then filt_len changed to 4 -> o updates on the next edge.
REQ-035 Scenario: CELRST pulsed with cnt=7 -> o=1 and cnt=0 immediately, with no chg pulse after release.
REQ-036 Scenario: N_IN=8, INV_OUT=0, en=0 with i=FF for 20 cycles -> o stays 0; en raised -> o=1 after filt_len+1 edges.
